// File: rtl/serial_code_feeder.sv
// Feeds entry/key bit streams MSB-first to a serial code comparator in a free-running 9-slot frame
// and reports the comparator result. Optional failed-attempt lockout under `FEEDER_LOCKOUT_EN.
module serial_code_feeder #(
    parameter int unsigned LOCK_FRAMES = 4,
    parameter int unsigned MAX_FAILS   = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] entry_i,
    input  logic       key_we_i,
    input  logic [7:0] key_in_i,
    input  logic       match_i,
    output logic       x_o,
    output logic       y_o,
    output logic       slot0_o,
    output logic       busy_o,
    output logic       result_valid_o,
    output logic       pass_o,
    output logic       locked_o
);

    typedef enum logic [1:0] {StIdle, StArmed, StSend, StCheck} state_e;

    if (LOCK_FRAMES == 0 || LOCK_FRAMES > 15 || MAX_FAILS == 0 || MAX_FAILS > 3) begin : g_bad_cfg
        $error("serial_code_feeder: LOCK_FRAMES or MAX_FAILS out of range");
    end

    state_e     state_q;
    logic [3:0] slot_q;
    logic [7:0] key_q;
    logic [7:0] entry_q;
    logic [7:0] entry_sr_q;
    logic [7:0] key_sr_q;
    logic       result_valid_q;
    logic       pass_q;
    logic       lock_active;
    logic       slot_last;
    logic       res_fire;

    assign slot_last = (slot_q == 4'd8);
    assign res_fire  = (state_q == StCheck) && slot_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            slot_q         <= 4'd0;
            key_q          <= 8'h00;
            entry_q        <= 8'h00;
            entry_sr_q     <= 8'h00;
            key_sr_q       <= 8'h00;
            result_valid_q <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            slot_q         <= slot_last ? 4'd0 : slot_q + 4'd1;
            unique case (state_q)
                StIdle: begin
                    if (key_we_i) key_q <= key_in_i;
                    if (load_i && !lock_active) begin
                        entry_q <= entry_i;
                        // Accepted in the result slot: the very next cycle is bit slot 0.
                        if (slot_last) begin
                            entry_sr_q <= entry_i;
                            key_sr_q   <= key_we_i ? key_in_i : key_q;
                            state_q    <= StSend;
                        end else begin
                            state_q <= StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (slot_last) begin
                        entry_sr_q <= entry_q;
                        key_sr_q   <= key_q;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    entry_sr_q <= {entry_sr_q[6:0], 1'b0};
                    key_sr_q   <= {key_sr_q[6:0], 1'b0};
                    if (slot_q == 4'd7) state_q <= StCheck;
                end
                StCheck: begin
                    if (slot_last) begin
                        pass_q         <= match_i;
                        result_valid_q <= 1'b1;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef FEEDER_LOCKOUT_EN
    logic [1:0] fail_cnt_q;
    logic [3:0] lock_cnt_q;
    logic       locked_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fail_cnt_q <= 2'd0;
            lock_cnt_q <= 4'd0;
            locked_q   <= 1'b0;
        end else if (res_fire) begin
            if (match_i) begin
                fail_cnt_q <= 2'd0;
            end else if (fail_cnt_q + 2'd1 == 2'(MAX_FAILS)) begin
                fail_cnt_q <= 2'd0;
                locked_q   <= 1'b1;
                lock_cnt_q <= 4'(LOCK_FRAMES);
            end else begin
                fail_cnt_q <= fail_cnt_q + 2'd1;
            end
        end else if (locked_q && slot_last) begin
            // The wrap that sets the lock is not counted; LOCK_FRAMES further wraps release it.
            lock_cnt_q <= lock_cnt_q - 4'd1;
            if (lock_cnt_q == 4'd1) locked_q <= 1'b0;
        end
    end

    assign lock_active = locked_q;
`else
    assign lock_active = 1'b0;
`endif

    // Outside SEND the streams disagree so the comparator always reports a mismatch.
    assign x_o            = (state_q == StSend) & entry_sr_q[7];
    assign y_o            = (state_q != StSend) | key_sr_q[7];
    assign slot0_o        = (slot_q == 4'd0);
    assign busy_o         = (state_q != StIdle);
    assign result_valid_o = result_valid_q;
    assign pass_o         = pass_q;
    assign locked_o       = lock_active;

endmodule
